// File: rtl/aes_round_sequencer.sv
// Iterative AES round controller: steps a shared combinational round datapath once per clock.
// Optional decryption key ordering and ds_decrypt flag are enabled by defining AES_DECRYPT_EN.
module aes_round_sequencer #(
  parameter  int NK    = 4,
  localparam int NR    = NK + 6,
  localparam int KEY_W = 128 * (NR + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             in_ready,
  input  logic [127:0]     plaintext,
  input  logic [KEY_W-1:0] key,
`ifdef AES_DECRYPT_EN
  input  logic             decrypt,
  output logic             ds_decrypt,
`endif
  output logic [127:0]     ds_state,
  output logic [127:0]     ds_key,
  output logic [3:0]       ds_round,
  output logic             ds_first,
  output logic             ds_last,
  input  logic [127:0]     dp_result,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     ciphertext
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  localparam logic [3:0] NR4 = 4'(NR);

  fsm_t         fsm, fsm_next;
  logic [127:0] state_reg, state_next;
  logic [127:0] cipher_reg, cipher_next;
  logic [3:0]   round, round_next;
  logic [3:0]   key_sel;
  logic         last_round;
`ifdef AES_DECRYPT_EN
  logic         dec_reg, dec_next;
`endif

  assign last_round = (round == NR4);

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm        <= IDLE;
      state_reg  <= '0;
      cipher_reg <= '0;
      round      <= '0;
`ifdef AES_DECRYPT_EN
      dec_reg    <= 1'b0;
`endif
    end else begin
      fsm        <= fsm_next;
      state_reg  <= state_next;
      cipher_reg <= cipher_next;
      round      <= round_next;
`ifdef AES_DECRYPT_EN
      dec_reg    <= dec_next;
`endif
    end
  end

  // Round index saturates at NR; it is only cleared on the next accepted job.
  always_comb begin
    fsm_next    = fsm;
    state_next  = state_reg;
    cipher_next = cipher_reg;
    round_next  = round;
`ifdef AES_DECRYPT_EN
    dec_next    = dec_reg;
`endif
    in_ready    = 1'b0;
    busy        = 1'b0;
    out_valid   = 1'b0;
    ds_first    = 1'b0;
    ds_last     = 1'b0;
    case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (start) begin
          fsm_next   = ROUND;
          state_next = plaintext;
          round_next = '0;
`ifdef AES_DECRYPT_EN
          dec_next   = decrypt;
`endif
        end
      end
      ROUND: begin
        busy       = 1'b1;
        ds_first   = (round == 4'd0);
        ds_last    = last_round;
        state_next = dp_result;
        if (last_round) begin
          cipher_next = dp_result;
          fsm_next    = DONE;
        end else begin
          round_next = round + 4'd1;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) fsm_next = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

`ifdef AES_DECRYPT_EN
  // Decryption walks the schedule from the round NR key down to round 0.
  assign key_sel    = dec_reg ? (NR4 - round) : round;
  assign ds_decrypt = dec_reg;
`else
  assign key_sel    = round;
`endif

  always_comb begin
    ds_key = '0;
    for (int unsigned r = 0; r < NR + 1; r++) begin
      if (key_sel == r[3:0]) ds_key = key[KEY_W-1-128*r -: 128];
    end
  end

  assign ds_state   = state_reg;
  assign ds_round   = round;
  assign ciphertext = cipher_reg;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: NK=4 and NK=8 instances with a reference AES round datapath
// attached, checked against FIPS-197 vectors and a whole-cipher model on random keys/blocks.
module tb_aes_round_sequencer;
  localparam int KW4 = 1408;
  localparam int KW8 = 1920;
  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P128 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C128 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] P256 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start4, in_ready4, busy4, out_valid4, out_ready4, first4, last4, dec4, dsdec4;
  logic [127:0] pt4, dss4, dsk4, dp4, ct4;
  logic [3:0] rnd4;
  logic [KW4-1:0] key4;
  logic start8, in_ready8, busy8, out_valid8, out_ready8, first8, last8, dsdec8;
  logic [127:0] pt8, dss8, dsk8, dp8, ct8;
  logic [3:0] rnd8;
  logic [KW8-1:0] key8;
  int total = 0;
  int bad = 0;

  aes_round_sequencer #(.NK(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .in_ready(in_ready4), .plaintext(pt4), .key(key4),
`ifdef AES_DECRYPT_EN
    .decrypt(dec4), .ds_decrypt(dsdec4),
`endif
    .ds_state(dss4), .ds_key(dsk4), .ds_round(rnd4), .ds_first(first4), .ds_last(last4),
    .dp_result(dp4), .busy(busy4), .out_valid(out_valid4), .out_ready(out_ready4),
    .ciphertext(ct4));

  aes_round_sequencer #(.NK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .in_ready(in_ready8), .plaintext(pt8), .key(key8),
`ifdef AES_DECRYPT_EN
    .decrypt(1'b0), .ds_decrypt(dsdec8),
`endif
    .ds_state(dss8), .ds_key(dsk8), .ds_round(rnd8), .ds_first(first8), .ds_last(last8),
    .dp_result(dp8), .busy(busy8), .out_valid(out_valid8), .out_ready(out_ready8),
    .ciphertext(ct8));

`ifndef AES_DECRYPT_EN
  assign dsdec4 = 1'b0;
  assign dsdec8 = 1'b0;
`endif

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, b;
    r = 8'h01; b = a;
    for (int i = 1; i < 8; i++) begin
      b = gmul(b, b);
      r = gmul(r, b);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = ginv(a);
    return i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] a);
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One datapath step; decryption uses the straight inverse cipher ordering.
  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] k,
                                             input logic first, input logic last, input logic dec);
    logic [7:0] a[16], b[16];
    logic [31:0] cw;
    logic [127:0] res;
    if (first) return st ^ k;
    for (int i = 0; i < 16; i++) a[i] = st[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        b[4*c+r] = dec ? isbox(a[4*((c+4-r)%4)+r]) : sbox(a[4*((c+r)%4)+r]);
    if (dec) for (int i = 0; i < 16; i++) b[i] ^= k[127-8*i -: 8];
    if (!last) begin
      cw = dec ? 32'h0e0b0d09 : 32'h02030101;
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          a[4*c+r] = '0;
          for (int j = 0; j < 4; j++) a[4*c+r] ^= gmul(cw[31-8*((j-r+4)%4) -: 8], b[4*c+j]);
        end
      for (int i = 0; i < 16; i++) b[i] = a[i];
    end
    if (!dec) for (int i = 0; i < 16; i++) b[i] ^= k[127-8*i -: 8];
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = b[i];
    return res;
  endfunction

  function automatic logic [KW8-1:0] expand(input logic [255:0] k, input int nk);
    logic [31:0] w[60];
    logic [31:0] t;
    logic [7:0] rc;
    logic [KW8-1:0] res;
    int nr;
    nr = nk + 6; rc = 8'h01; res = '0;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) res[KW8-1-128*r -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return res;
  endfunction

  function automatic logic [127:0] aes_model(input logic [127:0] blk, input logic [KW8-1:0] ks,
                                             input int nk, input logic dec);
    logic [127:0] s;
    int nr, kr;
    nr = nk + 6;
    kr = dec ? nr : 0;
    s = blk ^ ks[KW8-1-128*kr -: 128];
    for (int r = 1; r <= nr; r++) begin
      kr = dec ? nr - r : r;
      s = aes_round(s, ks[KW8-1-128*kr -: 128], 1'b0, r == nr, dec);
    end
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always_comb dp4 = aes_round(dss4, dsk4, first4, last4, dsdec4);
  always_comb dp8 = aes_round(dss8, dsk8, first8, last8, dsdec8);

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic job(input bit big, input logic [127:0] blk, input logic dec, output int edges,
                     output logic [127:0] ct, output logic [127:0] k0, output logic [127:0] k1,
                     output logic [15:0] fm, output logic [15:0] lm, output logic df);
    logic [3:0] r;
    if (big) begin pt8 = blk; start8 = 1'b1; end
    else begin pt4 = blk; dec4 = dec; start4 = 1'b1; end
    @(posedge clk); #1;
    start4 = 1'b0; start8 = 1'b0; pt4 = rnd128(); pt8 = rnd128();
    edges = 0; fm = '0; lm = '0; k0 = '0; k1 = '0;
    df = big ? dsdec8 : dsdec4;
    while (!(big ? out_valid8 : out_valid4) && edges < 40) begin
      r = big ? rnd8 : rnd4;
      if (big ? first8 : first4) fm[r] = 1'b1;
      if (big ? last8 : last4) lm[r] = 1'b1;
      if (r == 4'd0) k0 = big ? dsk8 : dsk4;
      if (r == 4'd1) k1 = big ? dsk8 : dsk4;
      @(posedge clk); #1;
      edges++;
    end
    ct = big ? ct8 : ct4;
  endtask

  task automatic drain(input bit big);
    if (big) out_ready8 = 1'b1; else out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0; out_ready8 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    start4 = 1'($urandom); start8 = 1'($urandom); pt4 = rnd128(); pt8 = rnd128();
    out_ready4 = 1'($urandom); out_ready8 = 1'($urandom);
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL rst_in_ready4 got=%b want=1", in_ready4); end
    total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL rst_busy4 got=%b want=0", busy4); end
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL rst_valid4 got=%b want=0", out_valid4); end
    total++; if (ct4 !== '0) begin bad++; $display("FAIL rst_ct4 got=%h want=0", ct4); end
    total++; if (rnd4 !== 4'd0) begin bad++; $display("FAIL rst_round4 got=%0d want=0", rnd4); end
    total++; if (dss4 !== '0) begin bad++; $display("FAIL rst_state4 got=%h want=0", dss4); end
    total++; if ({first4, last4} !== 2'b00) begin bad++; $display("FAIL rst_flags4 got=%b want=00", {first4, last4}); end
    total++; if ({in_ready8, busy8, out_valid8} !== 3'b100) begin bad++; $display("FAIL rst_ctl8 got=%b want=100", {in_ready8, busy8, out_valid8}); end
    total++; if (ct8 !== '0 || rnd8 !== 4'd0) begin bad++; $display("FAIL rst_out8 got=%h/%0d want=0/0", ct8, rnd8); end
    rst = 1'b0; start4 = 1'b0; start8 = 1'b0; out_ready4 = 1'b0; out_ready8 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fips128();
    logic [KW8-1:0] full;
    logic [127:0] ct, k0, k1;
    logic [15:0] fm, lm;
    logic df;
    int e;
    full = expand({K128, 128'h0}, 4);
    key4 = full[KW8-1 -: KW4];
    job(1'b0, P128, 1'b0, e, ct, k0, k1, fm, lm, df);
    total++; if (e != 11) begin bad++; $display("FAIL fips128_latency got=%0d want=11", e); end
    total++; if (ct !== C128) begin bad++; $display("FAIL fips128_ct got=%h want=%h", ct, C128); end
    total++; if (k1 !== RK1) begin bad++; $display("FAIL fips128_key1 got=%h want=%h", k1, RK1); end
    total++; if (k0 !== K128) begin bad++; $display("FAIL fips128_key0 got=%h want=%h", k0, K128); end
    total++; if (fm !== 16'h0001) begin bad++; $display("FAIL fips128_first got=%h want=0001", fm); end
    total++; if (lm !== 16'h0400) begin bad++; $display("FAIL fips128_last got=%h want=0400", lm); end
    total++; if ({first4, last4, in_ready4, busy4} !== 4'b0001) begin bad++; $display("FAIL fips128_done_ctl got=%b want=0001", {first4, last4, in_ready4, busy4}); end
    drain(1'b0);
    total++; if ({in_ready4, out_valid4, busy4} !== 3'b100) begin bad++; $display("FAIL fips128_idle got=%b want=100", {in_ready4, out_valid4, busy4}); end
  endtask

  task automatic test_random128();
    logic [KW8-1:0] full;
    logic [127:0] p, ct, exp_ct, k0, k1;
    logic [15:0] fm, lm;
    logic df;
    int e;
    for (int n = 0; n < 5; n++) begin
      full = expand({rnd128(), 128'h0}, 4);
      key4 = full[KW8-1 -: KW4];
      p = rnd128();
      exp_ct = aes_model(p, full, 4, 1'b0);
      job(1'b0, p, 1'b0, e, ct, k0, k1, fm, lm, df);
      total++; if (ct !== exp_ct || e != 11) begin bad++; $display("FAIL rand128_%0d got=%h/%0d want=%h/11", n, ct, e, exp_ct); end
      drain(1'b0);
    end
  endtask

  task automatic test_back_pressure();
    logic [KW8-1:0] full;
    logic [127:0] ct, k0, k1;
    logic [15:0] fm, lm;
    logic df;
    int e;
    full = expand({K128, 128'h0}, 4);
    key4 = full[KW8-1 -: KW4];
    job(1'b0, P128, 1'b0, e, ct, k0, k1, fm, lm, df);
    for (int c = 0; c < 5; c++) begin
      start4 = 1'($urandom); pt4 = rnd128();
      @(posedge clk); #1;
      total++; if (ct4 !== C128) begin bad++; $display("FAIL bp_ct_%0d got=%h want=%h", c, ct4, C128); end
      total++; if ({in_ready4, out_valid4} !== 2'b01) begin bad++; $display("FAIL bp_ctl_%0d got=%b want=01", c, {in_ready4, out_valid4}); end
    end
    start4 = 1'b0; out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    total++; if ({in_ready4, out_valid4, busy4} !== 3'b100) begin bad++; $display("FAIL bp_release got=%b want=100", {in_ready4, out_valid4, busy4}); end
    @(posedge clk); #1;
    total++; if ({in_ready4, busy4} !== 2'b10) begin bad++; $display("FAIL bp_no_second got=%b want=10", {in_ready4, busy4}); end
  endtask

  task automatic test_back_to_back();
    int n;
    start4 = 1'b1; pt4 = P128;
    @(posedge clk); #1;
    total++; if ({busy4, rnd4} !== 5'b10000) begin bad++; $display("FAIL b2b_accept got=%b want=10000", {busy4, rnd4}); end
    n = 0;
    while (!out_valid4 && n < 40) begin @(posedge clk); #1; n++; end
    total++; if (out_valid4 !== 1'b1 || n != 11) begin bad++; $display("FAIL b2b_done got=%b/%0d want=1/11", out_valid4, n); end
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    total++; if ({in_ready4, busy4} !== 2'b10) begin bad++; $display("FAIL b2b_idle got=%b want=10", {in_ready4, busy4}); end
    @(posedge clk); #1;
    total++; if ({in_ready4, busy4, rnd4} !== 6'b010000) begin bad++; $display("FAIL b2b_reaccept got=%b want=010000", {in_ready4, busy4, rnd4}); end
    start4 = 1'b0; out_ready4 = 1'b0;
    n = 0;
    while (!out_valid4 && n < 40) begin @(posedge clk); #1; n++; end
    total++; if (ct4 !== C128) begin bad++; $display("FAIL b2b_ct got=%h want=%h", ct4, C128); end
    drain(1'b0);
  endtask

  task automatic test_reset_mid();
    logic [127:0] ct, k0, k1;
    logic [15:0] fm, lm;
    logic df, seen;
    int n, e;
    start4 = 1'b1; pt4 = P128;
    @(posedge clk); #1;
    start4 = 1'b0;
    n = 0;
    while (rnd4 != 4'd5 && n < 20) begin @(posedge clk); #1; n++; end
    total++; if (rnd4 !== 4'd5) begin bad++; $display("FAIL mid_reach5 got=%0d want=5", rnd4); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if ({in_ready4, busy4, out_valid4} !== 3'b100) begin bad++; $display("FAIL mid_idle got=%b want=100", {in_ready4, busy4, out_valid4}); end
    total++; if (rnd4 !== 4'd0 || dss4 !== '0 || ct4 !== '0) begin bad++; $display("FAIL mid_regs got=%0d/%h/%h want=0/0/0", rnd4, dss4, ct4); end
    seen = 1'b0;
    for (int c = 0; c < 16; c++) begin @(posedge clk); #1; seen |= out_valid4; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_no_output got=%b want=0", seen); end
    job(1'b0, P128, 1'b0, e, ct, k0, k1, fm, lm, df);
    total++; if (ct !== C128 || e != 11) begin bad++; $display("FAIL mid_rerun got=%h/%0d want=%h/11", ct, e, C128); end
    drain(1'b0);
  endtask

  task automatic test_nk8();
    logic [KW8-1:0] full;
    logic [127:0] p, ct, exp_ct, k0, k1;
    logic [15:0] fm, lm;
    logic df;
    int e;
    key8 = expand(K256, 8);
    job(1'b1, P256, 1'b0, e, ct, k0, k1, fm, lm, df);
    total++; if (e != 15) begin bad++; $display("FAIL nk8_latency got=%0d want=15", e); end
    total++; if (ct !== C256) begin bad++; $display("FAIL nk8_ct got=%h want=%h", ct, C256); end
    total++; if (lm !== 16'h4000) begin bad++; $display("FAIL nk8_last got=%h want=4000", lm); end
    total++; if (fm !== 16'h0001) begin bad++; $display("FAIL nk8_first got=%h want=0001", fm); end
    total++; if (k1 !== K256[127:0]) begin bad++; $display("FAIL nk8_key1 got=%h want=%h", k1, K256[127:0]); end
    drain(1'b1);
    for (int n = 0; n < 3; n++) begin
      full = expand({rnd128(), rnd128()}, 8);
      key8 = full;
      p = rnd128();
      exp_ct = aes_model(p, full, 8, 1'b0);
      job(1'b1, p, 1'b0, e, ct, k0, k1, fm, lm, df);
      total++; if (ct !== exp_ct || e != 15) begin bad++; $display("FAIL rand256_%0d got=%h/%0d want=%h/15", n, ct, e, exp_ct); end
      drain(1'b1);
    end
  endtask

`ifdef AES_DECRYPT_EN
  task automatic test_decrypt();
    logic [KW8-1:0] full;
    logic [127:0] p, c, ct, k0, k1;
    logic [15:0] fm, lm;
    logic df;
    int e;
    full = expand({K128, 128'h0}, 4);
    key4 = full[KW8-1 -: KW4];
    job(1'b0, C128, 1'b1, e, ct, k0, k1, fm, lm, df);
    total++; if (k0 !== key4[127:0]) begin bad++; $display("FAIL dec_key0 got=%h want=%h", k0, key4[127:0]); end
    total++; if (df !== 1'b1) begin bad++; $display("FAIL dec_flag got=%b want=1", df); end
    total++; if (ct !== P128 || e != 11) begin bad++; $display("FAIL dec_fips got=%h/%0d want=%h/11", ct, e, P128); end
    drain(1'b0);
    for (int n = 0; n < 2; n++) begin
      full = expand({rnd128(), 128'h0}, 4);
      key4 = full[KW8-1 -: KW4];
      p = rnd128();
      c = aes_model(p, full, 4, 1'b0);
      job(1'b0, c, 1'b1, e, ct, k0, k1, fm, lm, df);
      total++; if (ct !== p) begin bad++; $display("FAIL dec_rand_%0d got=%h want=%h", n, ct, p); end
      drain(1'b0);
    end
    dec4 = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; start4 = 1'b0; start8 = 1'b0; out_ready4 = 1'b0; out_ready8 = 1'b0;
    dec4 = 1'b0; pt4 = '0; pt8 = '0; key4 = '0; key8 = '0;
    test_reset();
    test_fips128();
    test_random128();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid();
    test_nk8();
`ifdef AES_DECRYPT_EN
    test_decrypt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
